uart_core_param: RTL and testbench

Single-clock, parametrised UART transceiver. It replaces the divided-clock receiver/transmitter pair and its edge-detect glue with one block that runs entirely on clk, using clock-enable ticks. Data width, parity, stop bits and baud divisor are configurable. The user side is a valid/ready TX interface and a pulsed RX output with error flags. It sits between the encoder's byte stream logic and the board serial pins.

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/uart_core_param_if.sv | 29 ++
 rtl/uart_tick_gen.sv | 27 ++
 rtl/uart_core_param.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_core_param.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity modes, FSM state codes
// and the parity helper used by both the transmit and receive paths.
// No ports; pure package.
package uart_pkg;

    // Parity mode encoding for the PARITY parameter
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Widest payload the core supports; the parity helper works at this width
    localparam int MAX_DATA_BITS = 9;

    // Transmit FSM states
    localparam logic [2:0] TX_IDLE  = 3'd0;
    localparam logic [2:0] TX_START = 3'd1;
    localparam logic [2:0] TX_DATA  = 3'd2;
    localparam logic [2:0] TX_PAR   = 3'd3;
    localparam logic [2:0] TX_STOP  = 3'd4;

    // Receive FSM states
    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_PAR   = 3'd3;
    localparam logic [2:0] RX_STOP  = 3'd4;
    localparam logic [2:0] RX_BREAK = 3'd5;

    // Parity bit for a payload. Narrower payloads are zero-extended by the
    // caller, which leaves the XOR unchanged. Odd parity inverts the XOR so
    // that data plus parity bit carries an odd number of ones.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input int mode);
        logic p;
        p = ^data;
        case (mode)
            PAR_ODD:  return ~p;
            PAR_EVEN: return p;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_core_param_if.sv
// User-side bundle of the UART: valid/ready transmit request and the pulsed
// receive result with its error flags. master = byte-stream logic, slave = core.
// Ports: tx_data/tx_valid/rx_hold from master; tx_ready/tx_busy/rx_* from slave.
interface uart_core_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_overrun;
    logic                 rx_hold;

    modport master (
        output tx_data, tx_valid, rx_hold,
        input  tx_ready, tx_busy, rx_data, rx_valid,
               rx_parity_err, rx_frame_err, rx_overrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_hold,
        output tx_ready, tx_busy, rx_data, rx_valid,
               rx_parity_err, rx_frame_err, rx_overrun
    );
endinterface

// File: rtl/uart_tick_gen.sv
// Oversample clock-enable: one-cycle tick every DIV clk cycles.
// Latency: tick is combinational from the counter; clr restarts the phase.
// Backpressure: none, free running. Ports: clk, rst, clr in; tick out.
module uart_tick_gen #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_core_param.sv
// Single-clock UART transceiver: framed serial TX from a valid/ready byte port,
// oversampled RX to a one-cycle result pulse with parity/frame/overrun flags.
// Latency: start bit on the cycle after accept; rx_valid one cycle after the
// stop-bit sample. Backpressure: tx_ready low for the whole frame; RX cannot
// be stalled, rx_hold only flags overrun.
// Ports: clk, rst (sync, active-high); bus (slave side of uart_core_param_if);
// rx (async serial in); tx (serial out, idle high).
module uart_core_param
    import uart_pkg::*;
#(
    parameter int DIV       = 27,
    parameter int OVS       = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_core_param_if.slave         bus,
    input  logic                     rx,
    output logic                     tx
);
    localparam int BT = DIV * OVS;          // clk cycles per bit
    localparam int CW = $clog2(BT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int PW = $clog2(OVS);

    // ------------------------------------------------------------------
    // Transmit path. Bit timing comes from a down-counter loaded at accept,
    // so each bit is exactly BT cycles regardless of the RX tick phase.
    // ------------------------------------------------------------------
    logic [2:0]           tx_state;
    logic [CW-1:0]        tx_cnt;
    logic [DATA_BITS-1:0] tx_sh;
    logic [BW-1:0]        tx_idx;
    logic                 tx_par;
    logic                 tx_stop;
    logic                 tx_q;
    logic                 tx_rdy;

    assign tx_rdy       = (tx_state == TX_IDLE);
    assign bus.tx_ready = tx_rdy;
    assign bus.tx_busy  = ~tx_rdy;
    assign tx           = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_sh    <= '0;
            tx_idx   <= '0;
            tx_par   <= 1'b0;
            tx_stop  <= 1'b0;
            tx_q     <= 1'b1;
        end else if (tx_state == TX_IDLE) begin
            if (bus.tx_valid) begin
                tx_state <= TX_START;
                tx_q     <= 1'b0;
                tx_sh    <= bus.tx_data;
                tx_par   <= parity_bit(MAX_DATA_BITS'(bus.tx_data), PARITY);
                tx_cnt   <= CW'(BT - 1);
            end
        end else if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - 1'b1;
        end else begin
            // End of the current bit time: present the next bit.
            tx_cnt <= CW'(BT - 1);
            case (tx_state)
                TX_START: begin
                    tx_state <= TX_DATA;
                    tx_q     <= tx_sh[0];
                    tx_sh    <= tx_sh >> 1;
                    tx_idx   <= '0;
                end
                TX_DATA: begin
                    if (tx_idx == BW'(DATA_BITS - 1)) begin
                        if (PARITY != PAR_NONE) begin
                            tx_state <= TX_PAR;
                            tx_q     <= tx_par;
                        end else begin
                            tx_state <= TX_STOP;
                            tx_q     <= 1'b1;
                            tx_stop  <= 1'b0;
                        end
                    end else begin
                        tx_q   <= tx_sh[0];
                        tx_sh  <= tx_sh >> 1;
                        tx_idx <= tx_idx + 1'b1;
                    end
                end
                TX_PAR: begin
                    tx_state <= TX_STOP;
                    tx_q     <= 1'b1;
                    tx_stop  <= 1'b0;
                end
                TX_STOP: begin
                    // tx stays high; ready rises the cycle after the last stop cycle
                    if (tx_stop == 1'(STOP_BITS - 1)) begin
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_stop <= 1'b1;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_q     <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    logic rx_s1, rx_s2, rx_s3;   // s1/s2 synchroniser, s3 previous value for edge detect
    logic rx_fall;
    logic rx_tick;
    logic rx_tick_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset to idle level so a high line never looks like an edge
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_fall = rx_s3 & ~rx_s2;

    logic [2:0]           rx_state;
    logic [PW-1:0]        rx_ph;
    logic [BW-1:0]        rx_idx;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_par_bit;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 rx_perr_q;
    logic                 rx_ferr_q;
    logic                 rx_ovr_q;

    // Restarting the tick divider on the start edge keeps the mid-bit
    // sample point within one clk of the ideal position.
    assign rx_tick_clr = (rx_state == RX_IDLE) && rx_fall;

    uart_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (rx_tick_clr),
        .tick (rx_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            rx_ph      <= '0;
            rx_idx     <= '0;
            rx_sh      <= '0;
            rx_par_bit <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (rx_valid_q && bus.rx_hold) begin
                rx_ovr_q <= 1'b1;
            end

            case (rx_state)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state <= RX_START;
                        rx_ph    <= '0;
                    end
                end
                RX_START: begin
                    if (rx_tick) begin
                        if (rx_ph == PW'(OVS / 2 - 1)) begin
                            // Mid start bit: a high line means the edge was a glitch
                            rx_ph <= '0;
                            if (rx_s2) begin
                                rx_state <= RX_IDLE;
                            end else begin
                                rx_state <= RX_DATA;
                                rx_idx   <= '0;
                            end
                        end else begin
                            rx_ph <= rx_ph + 1'b1;
                        end
                    end
                end
                RX_DATA, RX_PAR, RX_STOP: begin
                    if (rx_tick) begin
                        if (rx_ph == PW'(OVS - 1)) begin
                            rx_ph <= '0;
                            if (rx_state == RX_DATA) begin
                                // LSB arrives first, so shift in from the top
                                rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                                if (rx_idx == BW'(DATA_BITS - 1)) begin
                                    rx_state <= (PARITY != PAR_NONE) ? RX_PAR : RX_STOP;
                                end else begin
                                    rx_idx <= rx_idx + 1'b1;
                                end
                            end else if (rx_state == RX_PAR) begin
                                rx_par_bit <= rx_s2;
                                rx_state   <= RX_STOP;
                            end else begin
                                rx_valid_q <= 1'b1;
                                rx_data_q  <= rx_sh;
                                rx_perr_q  <= (PARITY != PAR_NONE) &&
                                              (rx_par_bit != parity_bit(MAX_DATA_BITS'(rx_sh), PARITY));
                                rx_ferr_q  <= ~rx_s2;
                                // Line held low through the stop bit with zero data is a
                                // break; wait for it to release before looking for a start.
                                if (!rx_s2 && (rx_sh == '0)) begin
                                    rx_state <= RX_BREAK;
                                end else begin
                                    rx_state <= RX_IDLE;
                                end
                            end
                        end else begin
                            rx_ph <= rx_ph + 1'b1;
                        end
                    end
                end
                RX_BREAK: begin
                    if (rx_s2) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_parity_err = rx_perr_q;
    assign bus.rx_frame_err  = rx_ferr_q;
    assign bus.rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_core_param.sv
`timescale 1ns/1ps
module tb_uart_core_param;
    localparam int DIV = 4;
    localparam int OVS = 16;
    localparam int BT  = DIV * OVS;
    localparam int NI  = 3;   // instance g uses PARITY=g: 0 none, 1 odd, 2 even

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] tx_data  [NI];
    logic       tx_valid [NI];
    logic       rx_hold  [NI];
    logic       rx_drv   [NI];
    logic       loop_en  [NI];
    logic       tx_ready [NI];
    logic       tx_busy  [NI];
    logic       rx_valid [NI];
    logic       perr     [NI];
    logic       ferr     [NI];
    logic       ovr      [NI];
    logic       tx_line  [NI];
    logic [7:0] rx_data  [NI];

    for (genvar g = 0; g < NI; g++) begin : gu
        uart_core_param_if #(.DATA_BITS(8)) bus ();
        logic rx_in;
        assign rx_in        = loop_en[g] ? tx_line[g] : rx_drv[g];
        assign bus.tx_data  = tx_data[g];
        assign bus.tx_valid = tx_valid[g];
        assign bus.rx_hold  = rx_hold[g];
        assign tx_ready[g]  = bus.tx_ready;
        assign tx_busy[g]   = bus.tx_busy;
        assign rx_valid[g]  = bus.rx_valid;
        assign rx_data[g]   = bus.rx_data;
        assign perr[g]      = bus.rx_parity_err;
        assign ferr[g]      = bus.rx_frame_err;
        assign ovr[g]       = bus.rx_overrun;

        uart_core_param #(
            .DIV(DIV), .OVS(OVS), .DATA_BITS(8), .PARITY(g), .STOP_BITS(1)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus),
            .rx  (rx_in),
            .tx  (tx_line[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Every rx_valid pulse from any instance is logged here in arrival order
    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } rxev_t;
    rxev_t rxq[$];

    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (rx_valid[g] === 1'b1) rxq.push_back('{g, rx_data[g], perr[g], ferr[g]});
        end
    end

    // Reference: serial bit idx of a frame (0 start, 1..8 data LSB first,
    // then optional parity, then stop)
    function automatic logic exp_tx_bit(input int g, input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (g != 0 && idx == 9) return (^d) ^ (g == 1);
        return 1'b1;
    endfunction

    function automatic int frame_bits(input int g);
        return (g != 0) ? 11 : 10;
    endfunction

    task automatic tx_send_check(input int g, input logic [7:0] d, input string nm);
        int   n;
        logic rdy_seen;
        n = 0;
        while (tx_ready[g] !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        chk({nm, " ready_wait"}, tx_ready[g], 1);
        @(posedge clk); #1;
        tx_data[g] = d; tx_valid[g] = 1'b1;
        @(posedge clk); #1;          // accepted on this edge
        tx_valid[g] = 1'b0;
        tx_data[g] = ~d;             // must not affect the frame in flight
        rdy_seen = 1'b0;
        for (int b = 0; b < frame_bits(g); b++) begin
            logic e;
            logic seen;
            e = exp_tx_bit(g, d, b);
            seen = e;
            for (int k = 0; k < BT; k++) begin
                @(negedge clk);
                if (tx_line[g] !== e) seen = tx_line[g];
                if (tx_ready[g] !== 1'b0) rdy_seen = 1'b1;
            end
            chk($sformatf("%s bit%0d", nm, b), seen, e);
        end
        chk({nm, " ready_low_in_frame"}, rdy_seen, 0);
        @(negedge clk);
        chk({nm, " ready_after"}, tx_ready[g], 1);
        chk({nm, " busy_after"}, tx_busy[g], 0);
        chk({nm, " tx_idle"}, tx_line[g], 1);
    endtask

    task automatic send_rx(input int g, input logic [7:0] d, input logic flip, input logic stop_ok);
        logic b;
        for (int i = 0; i < 11; i++) begin
            if (i == 0) b = 1'b0;
            else if (i <= 8) b = d[i-1];
            else if (i == 9) begin
                if (g == 0) continue;
                b = (^d) ^ (g == 1) ^ flip;
            end else b = stop_ok;
            @(posedge clk); #1 rx_drv[g] = b;
            repeat (BT - 1) @(posedge clk);
        end
        @(posedge clk); #1 rx_drv[g] = 1'b1;
    endtask

    task automatic expect_rx(input int g, input logic [7:0] d, input logic pe, input logic fe,
                             input string nm);
        rxev_t ev;
        int    n;
        n = 0;
        while (rxq.size() == 0 && n < 2000) begin @(negedge clk); n++; end
        if (rxq.size() == 0) begin
            chk({nm, " rx_valid_seen"}, rxq.size(), 1);
        end else begin
            ev = rxq.pop_front();
            chk({nm, " inst"}, ev.inst, g);
            chk({nm, " data"}, ev.data, d);
            chk({nm, " parity_err"}, ev.pe, pe);
            chk({nm, " frame_err"}, ev.fe, fe);
        end
    endtask

    task automatic expect_none(input string nm);
        chk({nm, " no_extra_rx_valid"}, rxq.size(), 0);
        rxq.delete();
    endtask

    task automatic check_idle(input string nm);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("%s[%0d] tx", nm, g), tx_line[g], 1);
            chk($sformatf("%s[%0d] tx_ready", nm, g), tx_ready[g], 1);
            chk($sformatf("%s[%0d] tx_busy", nm, g), tx_busy[g], 0);
            chk($sformatf("%s[%0d] rx_valid", nm, g), rx_valid[g], 0);
            chk($sformatf("%s[%0d] rx_data", nm, g), rx_data[g], 0);
            chk($sformatf("%s[%0d] parity_err", nm, g), perr[g], 0);
            chk($sformatf("%s[%0d] frame_err", nm, g), ferr[g], 0);
            chk($sformatf("%s[%0d] overrun", nm, g), ovr[g], 0);
        end
    endtask

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       flip;
        logic       stop_ok;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vt[7];
        logic [7:0] lb[3];
        int         acc[3];
        int         n;

        vt[0] = '{1, 8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0};
        vt[1] = '{1, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
        vt[2] = '{2, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
        vt[3] = '{2, 8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
        vt[4] = '{0, 8'h7E, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1};
        vt[5] = '{0, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vt[6] = '{1, 8'h0F, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b1};

        for (int g = 0; g < NI; g++) begin
            tx_data[g] = 8'h00; tx_valid[g] = 1'b0; rx_hold[g] = 1'b0;
            rx_drv[g] = 1'b1; loop_en[g] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // 8N1 transmit of 0xA5 with exact bit timing
        tx_send_check(0, 8'hA5, "t1_a5");

        // Table of receive frames
        for (int i = 0; i < 7; i++) begin
            send_rx(vt[i].inst, vt[i].data, vt[i].flip, vt[i].stop_ok);
            expect_rx(vt[i].inst, vt[i].exp_data, vt[i].exp_pe, vt[i].exp_fe,
                      $sformatf("vec%0d", i));
            repeat (2 * BT) @(posedge clk);
            #1 chk($sformatf("vec%0d rx_data_held", i), rx_data[vt[i].inst], vt[i].exp_data);
            expect_none($sformatf("vec%0d", i));
        end

        // Short low glitch must not produce a frame
        @(posedge clk); #1 rx_drv[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1 rx_drv[0] = 1'b1;
        repeat (2 * BT) @(posedge clk);
        expect_none("glitch");
        send_rx(0, 8'h81, 1'b0, 1'b1);
        expect_rx(0, 8'h81, 1'b0, 1'b0, "after_glitch");
        expect_none("after_glitch");

        // Break: one frame-error result, then silence until the line releases
        @(posedge clk); #1 rx_drv[0] = 1'b0;
        repeat (20 * BT) @(posedge clk);
        expect_rx(0, 8'h00, 1'b0, 1'b1, "break");
        expect_none("break_hold");
        @(posedge clk); #1 rx_drv[0] = 1'b1;
        repeat (BT) @(posedge clk);
        send_rx(0, 8'h12, 1'b0, 1'b1);
        expect_rx(0, 8'h12, 1'b0, 1'b0, "after_break");
        expect_none("after_break");

        // Loopback, even parity, back-to-back
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h3C;
        loop_en[2] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            tx_data[2] = lb[i]; tx_valid[2] = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (tx_ready[2] !== 1'b1 && n < 2000);
            acc[i] = cyc;
            @(posedge clk); #1;
        end
        tx_valid[2] = 1'b0;
        chk("loop accept gap 0-1", acc[1] - acc[0], 11 * BT + 1);
        chk("loop accept gap 1-2", acc[2] - acc[1], 11 * BT + 1);
        for (int i = 0; i < 3; i++) expect_rx(2, lb[i], 1'b0, 1'b0, $sformatf("loop%0d", i));
        repeat (2 * BT) @(posedge clk);
        expect_none("loop");
        loop_en[2] = 1'b0;

        // Randomised receive frames against the frame rules
        for (int i = 0; i < 18; i++) begin
            int         g;
            logic [7:0] d;
            logic       fl, so;
            g  = $urandom_range(0, NI - 1);
            d  = 8'($urandom);
            fl = ($urandom_range(0, 3) == 0);
            so = ($urandom_range(0, 5) != 0);
            send_rx(g, d, fl, so);
            expect_rx(g, d, (g != 0) && fl, !so, $sformatf("rnd_rx%0d", i));
            repeat (2 * BT) @(posedge clk);
            expect_none($sformatf("rnd_rx%0d", i));
        end

        // Randomised transmit frames
        for (int i = 0; i < 5; i++) begin
            int g;
            g = $urandom_range(0, NI - 1);
            tx_send_check(g, 8'($urandom), $sformatf("rnd_tx%0d", i));
        end

        for (int g = 0; g < NI; g++) chk($sformatf("no_overrun[%0d]", g), ovr[g], 0);

        // Overrun when the consumer is holding
        rx_hold[2] = 1'b1;
        send_rx(2, 8'h5A, 1'b0, 1'b1);
        expect_rx(2, 8'h5A, 1'b0, 1'b0, "hold");
        repeat (4) @(posedge clk);
        #1;
        chk("overrun set", ovr[2], 1);
        chk("overrun other0", ovr[0], 0);
        chk("overrun other1", ovr[1], 0);
        rx_hold[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("overrun sticky", ovr[2], 1);

        // Reset in the middle of a TX frame and an RX frame
        @(posedge clk); #1;
        tx_data[0] = 8'hC3; tx_valid[0] = 1'b1; rx_drv[1] = 1'b0;
        @(posedge clk); #1;
        tx_valid[0] = 1'b0;
        repeat (299) @(posedge clk);
        #1;
        chk("mid_frame busy", tx_busy[0], 1);
        rst = 1'b1; rx_drv[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst tx high next cycle", tx_line[0], 1);
        chk("rst tx_ready next cycle", tx_ready[0], 1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_idle("after_rst");
        repeat (3 * BT) @(posedge clk);
        expect_none("after_rst");
        send_rx(1, 8'hE7, 1'b0, 1'b1);
        expect_rx(1, 8'hE7, 1'b0, 1'b0, "post_rst_rx");
        expect_none("post_rst_rx");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
